// File: rtl/dmem_pkg.sv
// Shared FSM encoding, limits and alignment helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LATENCY_MAX = 15;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

    // Enabled lanes must form one run starting at the byte offset; no lanes at all is a legal no-op.
    function automatic logic lanes_legal(input logic [1:0] lo, input logic [3:0] be);
        logic [3:0] below;
        logic [3:0] run;
        below = (4'b0001 << lo) - 4'b0001;
        run   = be >> lo;
        if (be == 4'b0000) return 1'b1;
        if ((be & below) != 4'b0000) return 1'b0;
        return (run == 4'b0001) || (run == 4'b0011) || (run == 4'b0111) || (run == 4'b1111);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage: synchronous byte-lane write port, asynchronous read port.
// No reset on contents; the write lands on the rising edge when we is high.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    lane_en,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    import dmem_pkg::*;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store target with LATENCY wait states (Stall for LATENCY+1 cycles, data/Err in the completion cycle).
// Optional DMEM_BYTE_LANE_EN adds ByteEn lane writes with lane-based alignment checking.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
`ifdef DMEM_BYTE_LANE_EN
    input  logic [3:0]  ByteEn,
`endif
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Err
);

    localparam int CW = $clog2(LATENCY_MAX + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam bit ZERO_WAIT = (LATENCY == 0);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          stall_c;

    logic          req;
    logic          oor;
    logic          align_bad;
    logic          addr_bad;
    logic          req_err;
    logic [AW-1:0] addr_idx;
    logic [3:0]    lane_req;

    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_data;
    logic [3:0]    lat_be;
    logic          lat_wr;
    logic          lat_addr_bad;
    logic          lat_err;

    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem_rdata;
    logic [31:0]   rd_now;
    logic          rd_bad;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_lane;
    logic [AW-1:0] mem_raddr;

    assign req      = MemRead | MemWrite;
    assign addr_idx = Addr[AW+1:2];
    assign oor      = (Addr >> (AW + 2)) != 32'd0;

`ifdef DMEM_BYTE_LANE_EN
    assign lane_req  = ByteEn;
    assign align_bad = !lanes_legal(Addr[1:0], ByteEn);
`else
    assign lane_req  = 4'b1111;
    assign align_bad = (Addr & WORD_ALIGN_MASK) != 32'd0;
`endif

    assign addr_bad = oor | align_bad;
    // Simultaneous read+write is performed as a write but still flagged.
    assign req_err  = addr_bad | (MemRead & MemWrite);

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (!ZERO_WAIT && req) begin
                    stall_c   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (cnt == '0) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_bad = ZERO_WAIT ? addr_bad : lat_addr_bad;
    assign rd_now = rd_bad ? 32'd0 : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            lat_idx      <= '0;
            lat_data     <= 32'd0;
            lat_be       <= 4'b0000;
            lat_wr       <= 1'b0;
            lat_addr_bad <= 1'b0;
            lat_err      <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= 1'b0;
            if (ZERO_WAIT) begin
                if (MemRead && !MemWrite) rdata_q <= rd_now;
            end else begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            lat_idx      <= addr_idx;
                            lat_data     <= WriteData;
                            lat_be       <= lane_req;
                            lat_wr       <= MemWrite;
                            lat_addr_bad <= addr_bad;
                            lat_err      <= req_err;
                            cnt          <= CNT_INIT;
                        end
                    end
                    WAIT: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            err_q <= lat_err;
                            if (!lat_wr) rdata_q <= rd_now;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Zero-wait writes commit on the request edge; otherwise on the DONE edge.
    assign mem_we    = ZERO_WAIT ? (MemWrite & ~addr_bad & ~reset)
                                 : ((state == DONE) & lat_wr & ~lat_addr_bad);
    assign mem_waddr = ZERO_WAIT ? addr_idx  : lat_idx;
    assign mem_wdata = ZERO_WAIT ? WriteData : lat_data;
    assign mem_lane  = ZERO_WAIT ? lane_req  : lat_be;
    assign mem_raddr = ZERO_WAIT ? addr_idx  : lat_idx;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .lane_en (mem_lane),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr   (mem_raddr),
        .rdata   (mem_rdata)
    );

    assign Stall    = stall_c & ~reset;
    assign Err      = ZERO_WAIT ? (req & req_err & ~reset) : err_q;
    assign ReadData = (ZERO_WAIT && MemRead && !MemWrite && !reset) ? rd_now : rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: one LATENCY=2 and one LATENCY=0 responder driven with random accesses against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int L2    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst0;
    logic        rd, wr, rd0, wr0;
    logic [31:0] addr, wdat, addr0, wdat0;
    logic [31:0] rdat, rdat0;
    logic        stall, err, stall0, err0;
    logic [3:0]  bd2, bd0;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(L2)) dut (
        .clk(clk), .reset(rst), .MemRead(rd), .MemWrite(wr), .Addr(addr), .WriteData(wdat),
`ifdef DMEM_BYTE_LANE_EN
        .ByteEn(bd2),
`endif
        .ReadData(rdat), .Stall(stall), .Err(err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .reset(rst0), .MemRead(rd0), .MemWrite(wr0), .Addr(addr0), .WriteData(wdat0),
`ifdef DMEM_BYTE_LANE_EN
        .ByteEn(bd0),
`endif
        .ReadData(rdat0), .Stall(stall0), .Err(err0)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: memory images, last load result, and per-cycle expected outputs.
    logic [31:0] m2 [DEPTH];
    logic [31:0] m0 [DEPTH];
    logic [31:0] last2, last0;
    logic        e_stall, e_err, e0_stall, e0_err;
    logic [31:0] e_rdata, e0_rdata;

    always @(negedge clk) begin
        check("stall",  {31'b0, stall},  {31'b0, e_stall});
        check("err",    {31'b0, err},    {31'b0, e_err});
        check("rdata",  rdat,            e_rdata);
        check("stall0", {31'b0, stall0}, {31'b0, e0_stall});
        check("err0",   {31'b0, err0},   {31'b0, e0_err});
        check("rdata0", rdat0,           e0_rdata);
    end

    function automatic bit illegal(input logic [31:0] a, input logic [3:0] b);
        int lo = int'(a[1:0]);
        bit ok = 1'b1;
        bit gap = 1'b0;
        if (a >= DEPTH * 4) return 1'b1;
        if (b == 4'b0000) return 1'b0;
        if (!b[lo]) ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < lo && b[i]) ok = 1'b0;
            if (i >= lo) begin
                if (b[i] && gap) ok = 1'b0;
                if (!b[i]) gap = 1'b1;
            end
        end
        return !ok;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom % 10)
            7:       return 32'h3FC;
            8:       return $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
            9:       return ($urandom % 2) ? 32'hFFFF_FFFC : 32'h400 + $urandom_range(0, 1000) * 4;
            default: return $urandom_range(0, 15) * 4;
        endcase
    endfunction

    task automatic acc2(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] grd, output bit gerr, output int nst);
        bit ab = illegal(a, bd2);
        bit e  = ab | (r & w);
        int idx = int'(a[9:2]);
        nst = 0;
        rd = r; wr = w; addr = a; wdat = d;
        e_stall = 1'b1; e_err = 1'b0; e_rdata = last2;
        @(negedge clk) if (stall) nst++;
        @(posedge clk) #1;
        for (int i = 0; i < L2; i++) begin
            addr = $urandom; wdat = $urandom;
            @(negedge clk) if (stall) nst++;
            @(posedge clk) #1;
        end
        addr = a; wdat = d;
        if (r && !w) last2 = ab ? 32'd0 : m2[idx];
        e_stall = 1'b0; e_err = e; e_rdata = last2;
        @(negedge clk) begin
            grd = rdat; gerr = err;
            if (stall) nst++;
        end
        @(posedge clk) #1;
        if (w && !ab) m2[idx] = merge(m2[idx], d, bd2);
        rd = 1'b0; wr = 1'b0;
        e_err = 1'b0; e_rdata = last2;
    endtask

    task automatic acc0(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] grd, output bit gerr);
        bit ab = illegal(a, bd0);
        int idx = int'(a[9:2]);
        rd0 = r; wr0 = w; addr0 = a; wdat0 = d;
        if (r && !w) last0 = ab ? 32'd0 : m0[idx];
        e0_stall = 1'b0; e0_err = ab | (r & w); e0_rdata = last0;
        @(negedge clk) begin
            grd = rdat0; gerr = err0;
        end
        @(posedge clk) #1;
        if (w && !ab) m0[idx] = merge(m0[idx], d, bd0);
        rd0 = 1'b0; wr0 = 1'b0;
        e0_err = 1'b0; e0_rdata = last0;
    endtask

    task automatic stream2();
        logic [31:0] g;
        bit ge;
        int n, op;
        for (int i = 0; i < 16; i++) acc2(0, 1, i * 4, $urandom, g, ge, n);
        acc2(0, 1, 32'h3FC, $urandom, g, ge, n);

        acc2(0, 1, 32'h10, 32'hDEADBEEF, g, ge, n);
        check("st_stall_cycles", n, 3);
        check("st_err", {31'b0, ge}, 0);
        acc2(1, 0, 32'h10, 32'h0, g, ge, n);
        check("ld_data", g, 32'hDEADBEEF);
        check("ld_err", {31'b0, ge}, 0);
        acc2(0, 1, 32'h11, 32'h55555555, g, ge, n);
        check("mis_err", {31'b0, ge}, 1);
        check("mis_stall_cycles", n, 3);
        acc2(1, 0, 32'h10, 32'h0, g, ge, n);
        check("mis_keep", g, 32'hDEADBEEF);
        acc2(1, 0, 32'h400, 32'h0, g, ge, n);
        check("oor_data", g, 32'h0);
        check("oor_err", {31'b0, ge}, 1);
        acc2(1, 1, 32'h14, 32'hCAFEF00D, g, ge, n);
        check("both_err", {31'b0, ge}, 1);
        acc2(1, 0, 32'h14, 32'h0, g, ge, n);
        check("both_wrote", g, 32'hCAFEF00D);

        // Reset while the store sits in WAIT: nothing may be written.
        acc2(0, 1, 32'h20, 32'h0BADF00D, g, ge, n);
        rd = 1'b0; wr = 1'b1; addr = 32'h20; wdat = 32'hA5A5A5A5;
        e_stall = 1'b1; e_err = 1'b0; e_rdata = last2;
        @(posedge clk) #1;
        rst = 1'b1; wr = 1'b0;
        last2 = 32'd0; e_stall = 1'b0; e_err = 1'b0; e_rdata = 32'd0;
        #1;
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_rdata", rdat, 32'h0);
        @(posedge clk) #1 rst = 1'b0;
        acc2(1, 0, 32'h20, 32'h0, g, ge, n);
        check("rst_keep", g, 32'h0BADF00D);

`ifdef DMEM_BYTE_LANE_EN
        acc2(0, 1, 32'h0, 32'h11223344, g, ge, n);
        bd2 = 4'b0011;
        acc2(0, 1, 32'h0, 32'hAAAABBCC, g, ge, n);
        check("lane_err", {31'b0, ge}, 0);
        bd2 = 4'b0101;
        acc2(0, 1, 32'h0, 32'hFFFFFFFF, g, ge, n);
        check("lane_gap_err", {31'b0, ge}, 1);
        bd2 = 4'b1111;
        acc2(1, 0, 32'h0, 32'h0, g, ge, n);
        check("lane_data", g, 32'h1122BBCC);
`endif

        repeat (300) begin
            op = $urandom % 8;
            if (op == 7) begin
                repeat ($urandom_range(1, 2)) begin
                    addr = $urandom; wdat = $urandom;
                    @(posedge clk) #1;
                end
            end else begin
                acc2(op < 3 || op == 6, op >= 3, rand_addr(), $urandom, g, ge, n);
            end
        end
    endtask

    task automatic stream0();
        logic [31:0] g;
        bit ge;
        int op;
        for (int i = 0; i < 16; i++) acc0(0, 1, i * 4, $urandom, g, ge);
        acc0(0, 1, 32'h3FC, $urandom, g, ge);

        acc0(0, 1, 32'h10, 32'h12345678, g, ge);
        acc0(1, 0, 32'h10, 32'h0, g, ge);
        check("z_data", g, 32'h12345678);
        check("z_err", {31'b0, ge}, 0);
        acc0(1, 0, 32'h13, 32'h0, g, ge);
        check("z_mis_data", g, 32'h0);
        check("z_mis_err", {31'b0, ge}, 1);

        repeat (300) begin
            op = $urandom % 8;
            if (op == 7) begin
                addr0 = $urandom; wdat0 = $urandom;
                @(posedge clk) #1;
            end else begin
                acc0(op < 3 || op == 6, op >= 3, rand_addr(), $urandom, g, ge);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rst0 = 1'b1;
        rd = 1'b0; wr = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
        addr = 32'd0; wdat = 32'd0; addr0 = 32'd0; wdat0 = 32'd0;
        bd2 = 4'b1111; bd0 = 4'b1111;
        last2 = 32'd0; last0 = 32'd0;
        e_stall = 1'b0; e_err = 1'b0; e_rdata = 32'd0;
        e0_stall = 1'b0; e0_err = 1'b0; e0_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst0 = 1'b0;
        fork
            stream2();
            stream0();
        join
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the datapath's load/store interface.
- Accepts one word access per instruction from the datapath: address from the ALU result, store data from the register-file read port, plus the MemRead/MemWrite controls.
- Inserts a programmable number of wait states and holds the PC register through Stall.
- Returns load data on ReadData in the cycle the access completes.

Parameters:
- DEPTH, 256, number of 32-bit words stored (power of two, >=4).
- LATENCY, 2, wait cycles per access (0..15); 0 means a zero-wait, single-cycle-compatible response.
- AW, $clog2(DEPTH), word-index width (derived; do not override).

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request, level, held by the datapath until Stall is low.
- MemWrite  in  1  store request, level, held likewise.
- Addr  in  32  byte address (datapath ALUResult).
- WriteData  in  32  store data.
- ReadData  out  32  load data, valid in the completion cycle.
- Stall  out  1  high, so the datapath holds PC and register writes.
- Err  out  1  one-cycle pulse on a misaligned or out-of-range access.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. While reset is asserted, FSM = IDLE, counter = 0, ReadData = 0, Stall = 0, Err = 0.
- Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no request (MemRead|MemWrite = 0): Stall = 0, ReadData holds its last value.
- IDLE with a request and LATENCY > 0:
  - Stall = 1 combinationally in the same cycle.
  - Latch Addr, WriteData and op; counter <= LATENCY-1; go to WAIT.
- WAIT: Stall = 1; counter decrements each cycle. When counter = 0, go to DONE.
- DONE:
  - Stall = 0.
  - Read: ReadData = mem[latched index], registered on the WAIT->DONE edge.
  - Write: mem[latched index] <= latched data on the DONE edge.
  - Go unconditionally to IDLE. The datapath advances at the end of DONE, so the still-present request is not re-accepted.
- LATENCY = 0: no WAIT/DONE.
  - Stall is never asserted.
  - ReadData = mem[Addr index] combinationally.
  - The write commits on the request-cycle edge.
- Total stall per access = LATENCY+1 cycles. Completion occurs LATENCY+1 cycles after the request is first seen.
- Word index: Addr[AW+1:2].
- Addr[1:0] != 0, or Addr >= DEPTH*4:
  - Err pulses in the completion cycle.
  - A write is dropped; a read returns 0.
  - The full stall timing is still applied.
- MemRead and MemWrite both high: treated as a write, and Err pulses.
- Inputs are ignored in WAIT/DONE; changes in those states do not alter the latched request.
- Reset mid-access: the access is abandoned, no write is committed, and the reset values above apply.

Optional Feature:
- Macro: DMEM_BYTE_LANE_EN.
- When defined:
  - Adds input ByteEn[3:0], latched with the request.
  - Writes update only the enabled byte lanes (lane i = bits 8i+7:8i).
  - Reads ignore ByteEn.
  - ByteEn = 0 on a write is a legal no-op.
  - Byte/halfword alignment is checked against the enabled lanes instead of Addr[1:0] = 0:
    - contiguous enables starting at Addr[1:0] are legal;
    - any other pattern raises Err.
- When undefined: no ByteEn port, and every write is full-word.

Decomposition:
- Shared package dmem_pkg: FSM state enum (IDLE/WAIT/DONE), the LATENCY range limit, and the word-alignment mask constant.
- One natural sub-module, dmem_array: a DEPTH x 32 storage array with one write port and one read port, plus a 4-bit lane write-enable. Without the macro, all four lanes are tied high.
- The FSM, counter and error checks stay in dmem_responder.

Test Plan:
- Store then load, LATENCY=2:
  - MemWrite, Addr=0x10, WriteData=0xDEADBEEF -> Stall high for 3 cycles, low in DONE.
  - Next MemRead, Addr=0x10 -> ReadData=0xDEADBEEF in the completion cycle, Err=0.
- LATENCY=0: MemRead to Addr=0x10 after a prior write of 0x12345678 -> Stall never high, ReadData=0x12345678 in the same cycle.
- Misaligned: MemWrite, Addr=0x11 -> Err one-cycle pulse at completion; a subsequent read of 0x10 returns the old value unchanged.
- Out of range, DEPTH=256: MemRead, Addr=0x400 -> ReadData=0, Err pulses.
- Reset mid-access: MemWrite, Addr=0x20, data 0xA5A5A5A5; assert reset in WAIT -> Stall=0 immediately; a later read of 0x20 returns the pre-existing value.
- With DMEM_BYTE_LANE_EN: mem[0x0]=0x11223344; write Addr=0x0, ByteEn=4'b0011, WriteData=0xAAAABBCC -> a read returns 0x1122BBCC.
